rename_fl: RTL

RENAME_FL -- requirements
Module: rename_fl

---
 rtl/rename_fl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rename_fl.sv
// rename_fl: rename stage with speculative/committed RATs and a circular freelist.
// Optional RENAME_WB_BYPASS_EN folds the writeback broadcast into source-ready bits.
module rename_fl #(
    parameter int N_ARCH    = 32,
    parameter int N_PHYS    = 64,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_in,
    output logic                                ready_out,
    input  logic [4:0]                          rs1_arch,
    input  logic [4:0]                          rs2_arch,
    input  logic [4:0]                          rd_arch,
    input  logic                                rd_used_in,
    input  logic [PAYLOAD_W-1:0]                payload_in,
    input  logic [N_PHYS-1:0]                   prf_valid,
    output logic                                valid_out,
    input  logic                                ready_in,
    output logic [PAYLOAD_W-1:0]                payload_out,
    output logic [PREG_W-1:0]                   rs1_tag_out,
    output logic [PREG_W-1:0]                   rs2_tag_out,
    output logic                                rs1_ready_out,
    output logic                                rs2_ready_out,
    output logic                                rd_used_out,
    output logic [PREG_W-1:0]                   rd_new_tag_out,
    output logic [PREG_W-1:0]                   rd_old_tag_out,
    input  logic                                commit_valid,
    input  logic                                commit_rd_used,
    input  logic [4:0]                          commit_rd_arch,
    input  logic [PREG_W-1:0]                   commit_new_tag,
    input  logic [PREG_W-1:0]                   commit_old_tag,
    input  logic                                flush,
    input  logic                                wb_valid,
    input  logic [PREG_W-1:0]                   wb_tag,
    output logic [$clog2(N_PHYS-N_ARCH+1)-1:0]  free_count
);
    localparam int FL = N_PHYS - N_ARCH;
    localparam int PW = $clog2(FL);
    localparam int CW = $clog2(N_PHYS - N_ARCH + 1);

    logic [PREG_W-1:0]    srat_q [N_ARCH];
    logic [PREG_W-1:0]    crat_q [N_ARCH];
    logic [PREG_W-1:0]    fl_q   [FL];
    logic [PW-1:0]        head_q, tail_q, chead_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 valid_q, rs1_rdy_q, rs2_rdy_q, rd_used_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PREG_W-1:0]    rs1_tag_q, rs2_tag_q, new_tag_q, old_tag_q;
    logic                 dest_alloc, accept, pop, commit_en, rs1_rdy, rs2_rdy;
    logic [PREG_W-1:0]    rs1_tag, rs2_tag, new_tag;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FL - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        dest_alloc = rd_used_in && rd_arch != '0;
        ready_out  = (!valid_q || ready_in) && !flush && (!dest_alloc || count_q != '0);
        accept     = valid_in && ready_out;
        pop        = accept && dest_alloc;
        commit_en  = commit_valid && commit_rd_used && commit_rd_arch != '0;
        rs1_tag    = srat_q[rs1_arch];
        rs2_tag    = srat_q[rs2_arch];
        new_tag    = fl_q[head_q];
`ifdef RENAME_WB_BYPASS_EN
        rs1_rdy    = rs1_arch == '0 || prf_valid[rs1_tag] || (wb_valid && wb_tag == rs1_tag);
        rs2_rdy    = rs2_arch == '0 || prf_valid[rs2_tag] || (wb_valid && wb_tag == rs2_tag);
`else
        rs1_rdy    = rs1_arch == '0 || prf_valid[rs1_tag];
        rs2_rdy    = rs2_arch == '0 || prf_valid[rs2_tag];
`endif
        // every committed allocation also frees one tag, so the committed freelist is always full
        count_d    = flush ? CW'(FL)
                   : (commit_en && !pop && count_q != CW'(FL)) ? count_q + 1'b1
                   : (pop && !commit_en) ? count_q - 1'b1 : count_q;
    end

`ifndef RENAME_WB_BYPASS_EN
    logic unused_ok;
    assign unused_ok = ^{wb_valid, wb_tag};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ARCH; i++) begin
                srat_q[i] <= PREG_W'(i);
                crat_q[i] <= PREG_W'(i);
            end
            for (int k = 0; k < FL; k++) fl_q[k] <= PREG_W'(N_ARCH + k);
            head_q    <= '0;
            tail_q    <= '0;
            chead_q   <= '0;
            count_q   <= CW'(FL);
            valid_q   <= 1'b0;
            payload_q <= '0;
            rs1_tag_q <= '0;
            rs2_tag_q <= '0;
            rs1_rdy_q <= 1'b0;
            rs2_rdy_q <= 1'b0;
            rd_used_q <= 1'b0;
            new_tag_q <= '0;
            old_tag_q <= '0;
        end else begin
            count_q <= count_d;
            if (commit_en) begin
                crat_q[commit_rd_arch] <= commit_new_tag;
                fl_q[tail_q]           <= commit_old_tag;
                tail_q                 <= inc(tail_q);
                chead_q                <= inc(chead_q);
            end
            if (flush) begin
                for (int i = 0; i < N_ARCH; i++)
                    srat_q[i] <= (commit_en && commit_rd_arch == 5'(i)) ? commit_new_tag : crat_q[i];
                head_q <= commit_en ? inc(chead_q) : chead_q;
            end else if (pop) begin
                srat_q[rd_arch] <= new_tag;
                head_q          <= inc(head_q);
            end
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q   <= 1'b1;
                payload_q <= payload_in;
                rs1_tag_q <= rs1_tag;
                rs2_tag_q <= rs2_tag;
                rs1_rdy_q <= rs1_rdy;
                rs2_rdy_q <= rs2_rdy;
                rd_used_q <= dest_alloc;
                new_tag_q <= dest_alloc ? new_tag : '0;
                old_tag_q <= srat_q[rd_arch];
            end else if (ready_in) begin
                valid_q <= 1'b0;
`ifdef RENAME_WB_BYPASS_EN
            end else if (valid_q && wb_valid) begin
                rs1_rdy_q <= rs1_rdy_q || wb_tag == rs1_tag_q;
                rs2_rdy_q <= rs2_rdy_q || wb_tag == rs2_tag_q;
`endif
            end
        end
    end

    assign valid_out      = valid_q;
    assign payload_out    = payload_q;
    assign rs1_tag_out    = rs1_tag_q;
    assign rs2_tag_out    = rs2_tag_q;
    assign rs1_ready_out  = rs1_rdy_q;
    assign rs2_ready_out  = rs2_rdy_q;
    assign rd_used_out    = rd_used_q;
    assign rd_new_tag_out = new_tag_q;
    assign rd_old_tag_out = old_tag_q;
    assign free_count     = count_q;
endmodule
